can_onchip_ram_pipelined: RTL and testbench



---
 rtl/can_onchip_ram_pipelined.sv | 151 +++++++++++++++
 tb/tb_can_onchip_ram_pipelined.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_onchip_ram_pipelined.sv
// ---------------------------------------------------------------------------
// can_onchip_ram_pipelined
//
// Single-port Avalon-MM on-chip RAM slave for the CAN controller Nios
// subsystem. Width, depth and read latency (1 or 2) are configurable. Reads
// are pipelined and return through readdatavalid. The slave stalls with
// waitrequest while clken is low or reset_req is high. Out-of-range reads
// answer SLAVEERROR with zero data, and out-of-range writes are dropped.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset (pipeline/control only)
//   clken          clock enable from the interconnect
//   reset_req      reset request, stalls the RAM like clken low
//   chipselect     slave select
//   read / write   transfer requests (write wins when both are set)
//   address        word address
//   byteenable     per-byte write enable
//   writedata      write data
//   waitrequest    high when no request can be accepted this cycle
//   readdata       read data, qualified by readdatavalid
//   readdatavalid  one strobe per accepted read
//   response       00 OKAY, 10 SLAVEERROR, qualified by readdatavalid
// ---------------------------------------------------------------------------
module can_onchip_ram_pipelined #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int DEPTH        = 1024,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = ""
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clken,
   input  logic                    reset_req,
   input  logic                    chipselect,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic [DATA_WIDTH-1:0]   writedata,
   output logic                    waitrequest,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid,
   output logic [1:0]              response
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_WIDTH is representable in the compare.
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   generate
      if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
         $error("can_onchip_ram_pipelined: READ_LATENCY must be 1 or 2");
      end
      if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
         $error("can_onchip_ram_pipelined: DEPTH must be 1..2**ADDR_WIDTH");
      end
      if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_width
         $error("can_onchip_ram_pipelined: DATA_WIDTH must be a multiple of 8 in 8..128");
      end
   endgenerate

   logic                  en;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  in_range;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign en          = clken & ~reset_req;
   assign waitrequest = ~en;
   assign in_range    = ({1'b0, address} < DEPTH_L);
   assign idx         = address[IDX_W-1:0];
   // A simultaneous read is dropped in favour of the write.
   assign wr_acc      = chipselect & write & en;
   assign rd_acc      = chipselect & read & ~write & en;

   // Memory array: never reset, so completed writes survive reset_n.
   always_ff @(posedge clk) begin
      if (wr_acc && in_range) begin
         for (int i = 0; i < BE_W; i++) begin
            if (byteenable[i]) begin
               mem[idx][8*i +: 8] <= writedata[8*i +: 8];
            end
         end
      end
   end

   // ---- stage 1: RAM output, valid and error captured at the accepting edge
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  vld_p1;
   logic                  err_p1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1  <= 1'b0;
         err_p1  <= 1'b0;
         data_p1 <= '0;
      end else if (en) begin
         vld_p1 <= rd_acc;
         if (rd_acc) begin
            err_p1  <= ~in_range;
            data_p1 <= in_range ? mem[idx] : '0;
         end
      end
   end

   logic [DATA_WIDTH-1:0] data_out;
   logic                  vld_out;
   logic                  err_out;

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         // ---- stage 2: output registers, loaded only when a beat moves in
         logic [DATA_WIDTH-1:0] data_p2;
         logic                  vld_p2;
         logic                  err_p2;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               vld_p2  <= 1'b0;
               err_p2  <= 1'b0;
               data_p2 <= '0;
            end else if (en) begin
               vld_p2 <= vld_p1;
               if (vld_p1) begin
                  err_p2  <= err_p1;
                  data_p2 <= data_p1;
               end
            end
         end

         assign data_out = data_p2;
         assign vld_out  = vld_p2;
         assign err_out  = err_p2;
      end else begin : g_lat1
         assign data_out = data_p1;
         assign vld_out  = vld_p1;
         assign err_out  = err_p1;
      end
   endgenerate

   // The final valid is masked by en: a held beat is presented only on the
   // first enabled cycle, and the pipeline advances past it on that edge.
   assign readdata      = data_out;
   assign readdatavalid = vld_out & en;
   assign response      = err_out ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_can_onchip_ram_pipelined.sv
// ---------------------------------------------------------------------------
// tb_can_onchip_ram_pipelined
//
// Self-checking bench for can_onchip_ram_pipelined. The DUT is built with
// 32-bit data, 10-bit addresses, DEPTH=768 and READ_LATENCY=2. A transaction
// model keeps a word array for the memory and a queue of outstanding reads;
// a read is expected on the READ_LATENCY-th enabled cycle after the cycle in
// which it was accepted. Each scenario task compares the beats it saw with
// the beats the model predicted, plus fixed values from the test plan.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_can_onchip_ram_pipelined;

   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int DEPTH = 768;
   localparam int LAT   = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          clken;
   logic          reset_req;
   logic          chipselect;
   logic          read;
   logic          write;
   logic [AW-1:0] address;
   logic [3:0]    byteenable;
   logic [DW-1:0] writedata;
   logic          waitrequest;
   logic [DW-1:0] readdata;
   logic          readdatavalid;
   logic [1:0]    response;

   always #5 clk = ~clk;

   can_onchip_ram_pipelined #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .DEPTH        (DEPTH),
      .READ_LATENCY (LAT),
      .INIT_FILE    ("")
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .clken         (clken),
      .reset_req     (reset_req),
      .chipselect    (chipselect),
      .read          (read),
      .write         (write),
      .address       (address),
      .byteenable    (byteenable),
      .writedata     (writedata),
      .waitrequest   (waitrequest),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .response      (response)
   );

   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] d;
      logic [1:0]  r;
   } beat_t;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  r;
      logic [31:0] n;
   } pend_t;

   beat_t       obs_q[$];
   beat_t       exp_q[$];
   pend_t       pend_q[$];
   logic [31:0] ref_mem [0:DEPTH-1];
   int          checks = 0;
   int          passed = 0;
   int unsigned cyc = 0;

   // One clock cycle: observe the outputs mid-cycle, update the model with
   // this cycle's inputs, then move to just after the next rising edge.
   task automatic tick();
      logic  en_now;
      beat_t b;
      pend_t p;
      @(negedge clk);
      if (readdatavalid === 1'b1) begin
         b.cyc = cyc; b.d = readdata; b.r = response;
         obs_q.push_back(b);
      end
      en_now = clken & ~reset_req;
      if (reset_n !== 1'b1) begin
         pend_q.delete();
      end else if (en_now) begin
         foreach (pend_q[i]) pend_q[i].n = pend_q[i].n + 1;
         if (pend_q.size() > 0 && pend_q[0].n == LAT) begin
            b.cyc = cyc; b.d = pend_q[0].d; b.r = pend_q[0].r;
            exp_q.push_back(b);
            void'(pend_q.pop_front());
         end
      end
      if (reset_n === 1'b1 && en_now && chipselect) begin
         if (write) begin
            if (address < DEPTH) begin
               for (int k = 0; k < 4; k++)
                  if (byteenable[k]) ref_mem[address][8*k +: 8] = writedata[8*k +: 8];
            end
         end else if (read) begin
            p.n = 0;
            if (address < DEPTH) begin p.d = ref_mem[address]; p.r = 2'b00; end
            else begin p.d = '0; p.r = 2'b10; end
            pend_q.push_back(p);
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
      address = '0; byteenable = '0; writedata = '0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      chipselect = 1'b1; write = 1'b1; read = 1'b0;
      address = a; writedata = d; byteenable = be;
      tick();
      set_idle();
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
      tick();
      set_idle();
   endtask

   task automatic flush();
      repeat (LAT + 3) tick();
   endtask

   task automatic start_scn();
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
      set_idle();
      repeat (3) tick();
      checks++;
      if (readdatavalid !== 1'b0) $display("FAIL reset_rdv: got %b expected 0", readdatavalid); else passed++;
      checks++;
      if (readdata !== 32'h0) $display("FAIL reset_readdata: got %h expected 00000000", readdata); else passed++;
      checks++;
      if (response !== 2'b00) $display("FAIL reset_response: got %b expected 00", response); else passed++;
      reset_n = 1'b1;
      tick();
      checks++;
      if (waitrequest !== 1'b0) $display("FAIL reset_waitrequest: got %b expected 0", waitrequest); else passed++;
   endtask

   task automatic test_write_read();
      int unsigned acc;
      start_scn();
      do_write(10'h005, 32'hDEADBEEF, 4'hF);
      acc = cyc;
      do_read(10'h005);
      flush();
      checks++;
      if (obs_q.size() != 1 || obs_q[0].d !== 32'hDEADBEEF || obs_q[0].r !== 2'b00 || obs_q[0].cyc != acc + LAT)
         $display("FAIL wr_rd_plan: got %0d beats first data=%h resp=%b cyc=%0d expected 1 beat DEADBEEF 00 cyc=%0d",
                  obs_q.size(), obs_q.size() ? obs_q[0].d : 32'h0, obs_q.size() ? obs_q[0].r : 2'b00,
                  obs_q.size() ? obs_q[0].cyc : 32'h0, acc + LAT);
      else passed++;
      checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL wr_rd_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i])
            $display("FAIL wr_rd_beat%0d: got cyc=%0d d=%h r=%b expected cyc=%0d d=%h r=%b", i,
                     obs_q[i].cyc, obs_q[i].d, obs_q[i].r, exp_q[i].cyc, exp_q[i].d, exp_q[i].r);
         else passed++;
      end
   endtask

   task automatic test_byte_enable();
      start_scn();
      do_write(10'h010, 32'h11223344, 4'hF);
      do_write(10'h010, 32'hAABBCCDD, 4'b0101);
      do_read(10'h010);
      flush();
      checks++;
      if (obs_q.size() != 1 || obs_q[0].d !== 32'h11BB33DD)
         $display("FAIL be_plan: got %0d beats data=%h expected 1 beat 11BB33DD", obs_q.size(), obs_q.size() ? obs_q[0].d : 32'h0);
      else passed++;
      checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL be_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i])
            $display("FAIL be_beat%0d: got cyc=%0d d=%h r=%b expected cyc=%0d d=%h r=%b", i,
                     obs_q[i].cyc, obs_q[i].d, obs_q[i].r, exp_q[i].cyc, exp_q[i].d, exp_q[i].r);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int unsigned first;
      for (int i = 0; i < 4; i++) do_write(AW'(i), 32'hA0 + i, 4'hF);
      start_scn();
      first = cyc;
      for (int i = 0; i < 4; i++) begin
         chipselect = 1'b1; read = 1'b1; address = AW'(i);
         tick();
      end
      set_idle();
      flush();
      checks++;
      if (obs_q.size() != 4) $display("FAIL b2b_count: got %0d expected 4", obs_q.size()); else passed++;
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
         checks++;
         if (obs_q[i].d !== 32'hA0 + i || obs_q[i].cyc != first + LAT + i)
            $display("FAIL b2b_beat%0d: got d=%h cyc=%0d expected d=%h cyc=%0d", i,
                     obs_q[i].d, obs_q[i].cyc, 32'hA0 + i, first + LAT + i);
         else passed++;
      end
      // Second burst with clken low for two cycles while address 2 is held.
      start_scn();
      for (int s = 0; s < 6; s++) begin
         chipselect = 1'b1; read = 1'b1;
         clken   = !(s == 2 || s == 3);
         address = (s < 2) ? AW'(s) : AW'(s - 2);
         if (s == 2 || s == 3) address = AW'(2);
         #1;
         if (s == 2 || s == 3) begin
            checks++;
            if (waitrequest !== 1'b1) $display("FAIL stall_waitrequest: got %b expected 1", waitrequest); else passed++;
         end
         tick();
      end
      clken = 1'b1;
      set_idle();
      flush();
      checks++;
      if (obs_q.size() != 4) $display("FAIL stall_count: got %0d expected 4", obs_q.size()); else passed++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i] || obs_q[i].d !== 32'hA0 + i)
            $display("FAIL stall_beat%0d: got cyc=%0d d=%h expected cyc=%0d d=%h", i,
                     obs_q[i].cyc, obs_q[i].d, exp_q[i].cyc, 32'hA0 + i);
         else passed++;
      end
   endtask

   task automatic test_out_of_range();
      start_scn();
      do_write(10'h2FF, 32'h0BADF00D, 4'hF);
      do_write(10'h300, 32'h12345678, 4'hF);
      do_read(10'h300);
      do_read(10'h2FF);
      do_read(10'h000);
      flush();
      checks++;
      if (obs_q.size() != 3) $display("FAIL oor_count: got %0d expected 3", obs_q.size()); else passed++;
      checks++;
      if (obs_q.size() < 1 || obs_q[0].r !== 2'b10 || obs_q[0].d !== 32'h0)
         $display("FAIL oor_error: got resp=%b data=%h expected 10 00000000",
                  obs_q.size() ? obs_q[0].r : 2'b00, obs_q.size() ? obs_q[0].d : 32'h0);
      else passed++;
      checks++;
      if (obs_q.size() < 3 || obs_q[1].d !== 32'h0BADF00D || obs_q[1].r !== 2'b00 || obs_q[2].d !== 32'hA0)
         $display("FAIL oor_neighbours: got %0d beats expected 0BADF00D/00 then 000000A0", obs_q.size());
      else passed++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i])
            $display("FAIL oor_beat%0d: got cyc=%0d d=%h r=%b expected cyc=%0d d=%h r=%b", i,
                     obs_q[i].cyc, obs_q[i].d, obs_q[i].r, exp_q[i].cyc, exp_q[i].d, exp_q[i].r);
         else passed++;
      end
   endtask

   task automatic test_reset_req();
      start_scn();
      reset_req = 1'b1;
      chipselect = 1'b1; read = 1'b1; address = 10'h005;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (waitrequest !== 1'b1) $display("FAIL rreq_waitrequest: got %b expected 1", waitrequest); else passed++;
         tick();
      end
      reset_req = 1'b0;
      tick();
      set_idle();
      flush();
      checks++;
      if (obs_q.size() != 1 || obs_q[0].d !== 32'hDEADBEEF)
         $display("FAIL rreq_beat: got %0d beats data=%h expected 1 beat DEADBEEF", obs_q.size(), obs_q.size() ? obs_q[0].d : 32'h0);
      else passed++;
      checks++;
      if (obs_q.size() != exp_q.size() || (obs_q.size() > 0 && obs_q[0] !== exp_q[0]))
         $display("FAIL rreq_model: got %0d beats expected %0d", obs_q.size(), exp_q.size());
      else passed++;
   endtask

   task automatic test_reset_inflight();
      int n_after;
      start_scn();
      do_read(10'h010);
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      flush();
      n_after = obs_q.size();
      checks++;
      if (n_after != 0) $display("FAIL inflight_discard: got %0d beats expected 0", n_after); else passed++;
      start_scn();
      do_read(10'h005);
      do_read(10'h010);
      flush();
      checks++;
      if (obs_q.size() != 2 || obs_q[0].d !== 32'hDEADBEEF || obs_q[1].d !== 32'h11BB33DD)
         $display("FAIL inflight_persist: got %0d beats expected DEADBEEF then 11BB33DD", obs_q.size());
      else passed++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i])
            $display("FAIL inflight_beat%0d: got cyc=%0d d=%h expected cyc=%0d d=%h", i,
                     obs_q[i].cyc, obs_q[i].d, exp_q[i].cyc, exp_q[i].d);
         else passed++;
      end
   endtask

   task automatic test_collision();
      start_scn();
      chipselect = 1'b1; read = 1'b1; write = 1'b1;
      address = 10'h020; writedata = 32'h55AA55AA; byteenable = 4'hF;
      tick();
      set_idle();
      flush();
      checks++;
      if (obs_q.size() != 0) $display("FAIL collide_no_beat: got %0d beats expected 0", obs_q.size()); else passed++;
      start_scn();
      do_read(10'h020);
      flush();
      checks++;
      if (obs_q.size() != 1 || obs_q[0].d !== 32'h55AA55AA)
         $display("FAIL collide_write: got %0d beats data=%h expected 55AA55AA", obs_q.size(), obs_q.size() ? obs_q[0].d : 32'h0);
      else passed++;
   endtask

   task automatic test_random();
      int unsigned r;
      for (int i = 0; i < 16; i++) do_write(AW'(i), $urandom, 4'hF);
      for (int i = 0; i < 4; i++) do_write(AW'(10'h2FC + i), $urandom, 4'hF);
      start_scn();
      for (int c = 0; c < 400; c++) begin
         clken      = ($urandom_range(0, 9) != 0);
         reset_req  = ($urandom_range(0, 14) == 0);
         chipselect = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 2);
         read  = (r != 1);
         write = (r != 0);
         r = $urandom_range(0, 9);
         if (r < 6)      address = AW'($urandom_range(0, 15));
         else if (r < 8) address = AW'(10'h2FC + $urandom_range(0, 3));
         else            address = AW'(10'h300 + $urandom_range(0, 255));
         byteenable = 4'($urandom);
         writedata  = $urandom;
         tick();
      end
      clken = 1'b1; reset_req = 1'b0;
      set_idle();
      flush();
      checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i])
            $display("FAIL rand_beat%0d: got cyc=%0d d=%h r=%b expected cyc=%0d d=%h r=%b", i,
                     obs_q[i].cyc, obs_q[i].d, obs_q[i].r, exp_q[i].cyc, exp_q[i].d, exp_q[i].r);
         else passed++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
      set_idle();
      test_reset();
      test_write_read();
      test_byte_enable();
      test_back_to_back();
      test_out_of_range();
      test_reset_req();
      test_reset_inflight();
      test_collision();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
